gate_exhaustive_checker: RTL and testbench
==========================================

Name: gate_exhaustive_checker

Overview:
- Sequential stimulus/response engine for small combinational gates, such as the 2-input XNOR in guide 5.
- On start, it applies every input vector to the gate under test and waits a programmable settle time.
- After settling, it samples the gate output and compares it against a parameterised truth table.
- It counts mismatches and reports pass/fail. It replaces hand-written per-vector test sequences with a reusable synthesizable block.

Parameters:
- N_IN, 2, number of gate inputs driven (1..4).
- TRUTH, 4'b1001, expected gate output per vector; bit i = expected output for dut_in == i; width 2**N_IN.
- SETTLE, 1, clock cycles dut_in is held stable before sampling (minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  run request; sampled only in IDLE.
- dut_in  output  N_IN  registered stimulus to gate under test.
- dut_out  input  1  gate under test response.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  1 when the last completed run had zero mismatches; held until the next accepted start.
- fail_count  output  N_IN+1  mismatches in the current/last run.
- fail_valid  output  1  at least one mismatch captured in the current/last run.
- first_fail_vec  output  N_IN  vector index of the first mismatch; valid when fail_valid=1.

Behaviour:
- Reset (rst_n=0 at rising edge):
  - state=IDLE, dut_in=0, busy=0, done=0, pass=0, fail_count=0, fail_valid=0, first_fail_vec=0.
  - Internal vec and settle counters are cleared.
  - Reset has priority over everything, including mid-run. No partial results survive.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - busy=0.
  - start=1 → vec<=0, dut_in<=0, cnt<=0, fail_count<=0, fail_valid<=0, pass<=0, first_fail_vec<=0; go to WAIT.
- WAIT:
  - busy=1.
  - cnt increments each cycle.
  - When cnt==SETTLE-1, go to CHECK. With SETTLE=1, WAIT lasts exactly 1 cycle.
- CHECK (exactly 1 cycle):
  - busy=1.
  - Compare dut_out with TRUTH[vec]. On mismatch: fail_count<=fail_count+1.
  - On mismatch with fail_valid=0: first_fail_vec<=vec and fail_valid<=1.
  - If vec==2**N_IN-1, go to DONE.
  - Otherwise vec<=vec+1, dut_in<=vec+1, cnt<=0; go to WAIT.
- DONE (exactly 1 cycle):
  - done=1, busy=1.
  - pass<=(fail_count==0), using the final count including the last CHECK.
  - Go to IDLE. dut_in keeps its last vector until the next start.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - done is high in the cycle following the 2**N_IN*(SETTLE+1)-th rising edge after the edge that accepted start. Default: 8 edges.
  - dut_in changes only on the CHECK→WAIT transition and on start acceptance. It is never changed while sampling.
- Comparison rules:
  - Comparison is a 1-bit equality.
  - In simulation, X/Z on dut_out counts as a mismatch (use case-inequality semantics in the compare).
- fail_count width N_IN+1 holds the maximum 2**N_IN with no wrap.
- start while busy (WAIT/CHECK/DONE) is ignored, not queued.
- start held high continuously gives back-to-back runs. The next run is accepted in the IDLE cycle after DONE.
- pass is 0 during a run, so pass=1 is only ever a completed, clean result.

Test Plan:
- XNOR gate connected (out = ~(a^b) on dut_in[1:0]), defaults, start pulse → dut_in sequence 0,1,2,3 each held 2 cycles; done at edge 8; pass=1, fail_count=0, fail_valid=0.
- XOR gate connected, defaults → fail_count=4, fail_valid=1, first_fail_vec=0, pass=0.
- dut_out tied to 0 → mismatches at vectors 0 and 3 only; fail_count=2, first_fail_vec=0, pass=0.
- Run the XOR case, then rerun with the XNOR gate → second run reports fail_count=0, fail_valid=0, pass=1. start pulses at cycles 2 and 5 of the run are ignored, and exactly one done pulse occurs per run.
- rst_n=0 during WAIT of vector 2 → next edge: all outputs at reset values, state IDLE. A fresh start completes normally with pass=1.
- SETTLE=3, XNOR gate → each vector held 4 cycles; done at edge 16; dut_out sampled only in the 4th cycle of each vector. A glitch injected on dut_out in cycles 1–3 does not affect the result.

Source files
------------

// File: rtl/gate_exhaustive_checker.sv
// Purpose: drives every input vector into a small gate and checks each response against TRUTH.
// Latency: 2**N_IN*(SETTLE+1) cycles from the edge that accepts start to the done pulse.
// Backpressure: none; start is only sampled in IDLE, and a start seen while busy is dropped.
module gate_exhaustive_checker #(
    parameter int                     N_IN   = 2,
    parameter logic [(2**N_IN)-1:0]   TRUTH  = 4'b1001,
    parameter int                     SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t          state;
    logic [N_IN-1:0] vec;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            vec            <= '0;
            cnt            <= '0;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec            <= '0;
                        dut_in         <= '0;
                        cnt            <= '0;
                        fail_count     <= '0;
                        fail_valid     <= 1'b0;
                        pass           <= 1'b0;
                        first_fail_vec <= '0;
                        busy           <= 1'b1;
                        state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Case inequality so an X/Z response is scored as a mismatch.
                    if (dut_out !== TRUTH[vec]) begin
                        fail_count <= fail_count + 1'b1;
                        if (!fail_valid) begin
                            first_fail_vec <= vec;
                            fail_valid     <= 1'b1;
                        end
                    end
                    if (vec == VEC_LAST) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        vec    <= vec + 1'b1;
                        dut_in <= vec + 1'b1;
                        cnt    <= '0;
                        state  <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    // fail_count already includes the final CHECK here.
                    pass  <= (fail_count == '0);
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Directed bench: default checker against several gate models, plus a SETTLE=3 instance with glitches.
module tb_gate_exhaustive_checker;

    logic       clk;
    logic       rst_n;
    logic       start, start2;
    logic [1:0] dut_in, dut_in2;
    logic       dut_out, dut_out2;
    logic       busy, done, pass, fail_valid;
    logic       busy2, done2, pass2, fail_valid2;
    logic [2:0] fail_count, fail_count2;
    logic [1:0] first_fail_vec, first_fail_vec2;
    logic [1:0] gate;
    logic       glitch;

    int total = 0;
    int bad   = 0;

    gate_exhaustive_checker #(.N_IN(2), .TRUTH(4'b1001), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .fail_valid(fail_valid), .first_fail_vec(first_fail_vec)
    );

    gate_exhaustive_checker #(.N_IN(2), .TRUTH(4'b1001), .SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_in(dut_in2), .dut_out(dut_out2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_count(fail_count2),
        .fail_valid(fail_valid2), .first_fail_vec(first_fail_vec2)
    );

    // Gate models: 0 XNOR, 1 XOR, 2 tied low, 3 tied high.
    always_comb begin
        dut_out = 1'b0;
        case (gate)
            2'd0: dut_out = ~(dut_in[1] ^ dut_in[0]);
            2'd1: dut_out = dut_in[1] ^ dut_in[0];
            2'd2: dut_out = 1'b0;
            default: dut_out = 1'b1;
        endcase
    end

    assign dut_out2 = ~(dut_in2[1] ^ dut_in2[0]) ^ glitch;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_check(input logic [1:0] g, input bit pulses, output int dcnt);
        gate  = g;
        start = 1'b1;
        tick();
        start = 1'b0;
        dcnt  = 0;
        for (int e = 0; e < 12; e++) begin
            if (done === 1'b1) dcnt++;
            start = (pulses && (e == 2 || e == 5)) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; gate = 2'd0; glitch = 1'b0;
        tick(); tick();
        total++; if (dut_in !== 2'd0) begin bad++; $display("FAIL reset_dut_in got=%0h exp=0", dut_in); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%0b exp=0", pass); end
        total++; if (fail_count !== 3'd0) begin bad++; $display("FAIL reset_fail_count got=%0d exp=0", fail_count); end
        total++; if (fail_valid !== 1'b0) begin bad++; $display("FAIL reset_fail_valid got=%0b exp=0", fail_valid); end
        total++; if (first_fail_vec !== 2'd0) begin bad++; $display("FAIL reset_first got=%0d exp=0", first_fail_vec); end
        total++; if (busy2 !== 1'b0 || dut_in2 !== 2'd0) begin bad++; $display("FAIL reset_s3 got=%0b/%0h exp=0/0", busy2, dut_in2); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_xnor_timing();
        gate  = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 8; e++) begin
            total++; if (dut_in !== 2'(e / 2)) begin bad++; $display("FAIL xnor_dut_in e=%0d got=%0h exp=%0h", e, dut_in, e / 2); end
            total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL xnor_busy_done e=%0d got=%0b%0b exp=10", e, busy, done); end
            tick();
        end
        total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL xnor_done_edge8 got=%0b%0b exp=11", done, busy); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL xnor_idle got=%0b%0b exp=00", done, busy); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL xnor_pass got=%0b exp=1", pass); end
        total++; if (fail_count !== 3'd0 || fail_valid !== 1'b0) begin bad++; $display("FAIL xnor_fail got=%0d/%0b exp=0/0", fail_count, fail_valid); end
        total++; if (dut_in !== 2'd3) begin bad++; $display("FAIL xnor_hold_last got=%0h exp=3", dut_in); end
    endtask

    task automatic test_xor();
        int d;
        run_check(2'd1, 1'b0, d);
        total++; if (fail_count !== 3'd4) begin bad++; $display("FAIL xor_count got=%0d exp=4", fail_count); end
        total++; if (fail_valid !== 1'b1 || first_fail_vec !== 2'd0) begin bad++; $display("FAIL xor_first got=%0b/%0d exp=1/0", fail_valid, first_fail_vec); end
        total++; if (pass !== 1'b0 || d != 1) begin bad++; $display("FAIL xor_pass_done got=%0b/%0d exp=0/1", pass, d); end
    endtask

    task automatic test_stuck();
        int d;
        run_check(2'd2, 1'b0, d);
        total++; if (fail_count !== 3'd2 || first_fail_vec !== 2'd0) begin bad++; $display("FAIL stuck0 got=%0d/%0d exp=2/0", fail_count, first_fail_vec); end
        total++; if (pass !== 1'b0 || fail_valid !== 1'b1) begin bad++; $display("FAIL stuck0_flags got=%0b/%0b exp=0/1", pass, fail_valid); end
        run_check(2'd3, 1'b0, d);
        total++; if (fail_count !== 3'd2 || first_fail_vec !== 2'd1) begin bad++; $display("FAIL stuck1 got=%0d/%0d exp=2/1", fail_count, first_fail_vec); end
    endtask

    task automatic test_rerun();
        int d;
        run_check(2'd1, 1'b1, d);
        total++; if (fail_count !== 3'd4 || d != 1) begin bad++; $display("FAIL rerun_xor got=%0d/%0d exp=4/1", fail_count, d); end
        run_check(2'd0, 1'b1, d);
        total++; if (fail_count !== 3'd0 || fail_valid !== 1'b0) begin bad++; $display("FAIL rerun_xnor_fail got=%0d/%0b exp=0/0", fail_count, fail_valid); end
        total++; if (pass !== 1'b1 || d != 1) begin bad++; $display("FAIL rerun_xnor_pass got=%0b/%0d exp=1/1", pass, d); end
    endtask

    task automatic test_back_to_back();
        int d = 0;
        gate  = 2'd0;
        start = 1'b1;
        tick();
        for (int e = 0; e < 20; e++) begin
            if (done === 1'b1) d++;
            if (e == 9) begin
                total++; if (busy !== 1'b0 || dut_in !== 2'd3) begin bad++; $display("FAIL b2b_gap got=%0b/%0h exp=0/3", busy, dut_in); end
            end
            if (e == 10) begin
                total++; if (busy !== 1'b1 || dut_in !== 2'd0) begin bad++; $display("FAIL b2b_restart got=%0b/%0h exp=1/0", busy, dut_in); end
            end
            if (e == 19) start = 1'b0;
            tick();
        end
        total++; if (d != 2 || pass !== 1'b1) begin bad++; $display("FAIL b2b_dones got=%0d/%0b exp=2/1", d, pass); end
        tick();
    endtask

    task automatic test_reset_mid();
        int d;
        gate  = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        total++; if (dut_in !== 2'd2 || fail_count !== 3'd2) begin bad++; $display("FAIL mid_pre got=%0h/%0d exp=2/2", dut_in, fail_count); end
        rst_n = 1'b0;
        tick();
        total++; if (dut_in !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl got=%0h/%0b/%0b exp=0/0/0", dut_in, busy, done); end
        total++; if (fail_count !== 3'd0 || fail_valid !== 1'b0 || pass !== 1'b0) begin bad++; $display("FAIL mid_rst_res got=%0d/%0b/%0b exp=0/0/0", fail_count, fail_valid, pass); end
        rst_n = 1'b1;
        tick();
        run_check(2'd0, 1'b0, d);
        total++; if (pass !== 1'b1 || d != 1) begin bad++; $display("FAIL mid_rerun got=%0b/%0d exp=1/1", pass, d); end
    endtask

    task automatic test_settle3();
        glitch = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int e = 0; e < 16; e++) begin
            total++; if (dut_in2 !== 2'(e / 4) || done2 !== 1'b0) begin bad++; $display("FAIL s3_seq e=%0d got=%0h/%0b exp=%0h/0", e, dut_in2, done2, e / 4); end
            glitch = ((e % 4) != 3);
            tick();
        end
        glitch = 1'b0;
        total++; if (done2 !== 1'b1) begin bad++; $display("FAIL s3_done_edge16 got=%0b exp=1", done2); end
        tick();
        total++; if (pass2 !== 1'b1 || fail_count2 !== 3'd0 || fail_valid2 !== 1'b0) begin bad++; $display("FAIL s3_result got=%0b/%0d/%0b exp=1/0/0", pass2, fail_count2, fail_valid2); end
    endtask

    initial begin
        test_reset();
        test_xnor_timing();
        test_xor();
        test_stuck();
        test_rerun();
        test_back_to_back();
        test_reset_mid();
        test_settle3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
